// File: rtl/alu_seq.sv
// Clocked 16-op ALU with registered results and flags. MUL and DIV run over
// WIDTH iterations behind a valid/ready handshake; all other ops take one cycle.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic             CarryOut,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             div0
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;     // MUL high half / DIV partial remainder
  logic [WIDTH-1:0] r_q;       // MUL multiplier->low half / DIV dividend->quotient
  logic [WIDTH-1:0] r_m;       // multiplicand or divisor
  logic             r_is_div;

  logic             w_accept;
  logic             w_is_iter_op;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign in_ready     = (r_state != S_ITER);
  assign w_accept     = in_valid && in_ready;
  assign w_is_iter_op = (ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV);

  // Single-cycle result path, evaluated on the live operands at the accept edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        {w_carry, w_res} = {1'b0, A} + {1'b0, B};
        w_ovf = (A[MSB] == B[MSB]) && (w_res[MSB] != A[MSB]);
      end
      OP_SUB: begin
        {w_carry, w_res} = {1'b0, A} - {1'b0, B};
        w_ovf = (A[MSB] != B[MSB]) && (w_res[MSB] != A[MSB]);
      end
      OP_SHL: begin w_res = {A[MSB-1:0], 1'b0};   w_carry = A[MSB]; end
      OP_SHR: begin w_res = {1'b0, A[MSB:1]};     w_carry = A[0];   end
      OP_ROL: begin w_res = {A[MSB-1:0], A[MSB]}; w_carry = A[MSB]; end
      OP_ROR: begin w_res = {A[0], A[MSB:1]};     w_carry = A[0];   end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOR:  w_res = ~(A | B);
      OP_NAND: w_res = ~(A & B);
      OP_XNOR: w_res = ~(A ^ B);
      OP_GT:   w_res[0] = (A > B);
      OP_EQ:   w_res[0] = (A == B);
      default: ;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring shift-subtract for DIV.
  // A zero divisor needs no special case: every step subtracts nothing, so the
  // quotient fills with ones and the dividend shifts whole into the remainder.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_m};
  assign w_shift = {r_acc, r_q[MSB]};
  assign w_diff  = w_shift[WIDTH-1:0] - r_m;

  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_is_div) begin
      if (w_shift >= {1'b0, r_m}) begin
        w_acc_nxt = w_diff;
        w_q_nxt   = {r_q[MSB-1:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[WIDTH-1:0];
        w_q_nxt   = {r_q[MSB-1:0], 1'b0};
      end
    end else if (r_q[0]) begin
      {w_acc_nxt, w_q_nxt} = {w_sum, r_q[MSB:1]};
    end else begin
      {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[MSB:1]};
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_is_div  <= 1'b0;
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      ALU_Hi    <= '0;
      CarryOut  <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_ITER: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
            ALU_Out   <= w_q_nxt;
            ALU_Hi    <= w_acc_nxt;
            CarryOut  <= !r_is_div && (w_acc_nxt != '0);
            ovf       <= 1'b0;
            div0      <= r_is_div && (r_m == '0);
            zero      <= (w_q_nxt == '0);
            neg       <= w_q_nxt[MSB];
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE lasts exactly one cycle.
          r_state <= S_IDLE;
          if (w_accept) begin
            if (w_is_iter_op) begin
              r_state  <= S_ITER;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_q      <= A;
              r_m      <= B;
              r_is_div <= (ALU_Sel == OP_DIV);
            end else begin
              out_valid <= 1'b1;
              ALU_Out   <= w_res;
              ALU_Hi    <= '0;
              CarryOut  <= w_carry;
              ovf       <= w_ovf;
              div0      <= 1'b0;
              zero      <= (w_res == '0);
              neg       <= w_res[MSB];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an arithmetic reference model predicts every
// result, its timing and in_ready; one negedge process compares each cycle.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid;
  logic [W-1:0]  A, B, ALU_Out, ALU_Hi;
  logic [3:0]    ALU_Sel;
  logic          CarryOut, zero, neg, ovf, div0;

  logic          iv16, rdy16, ov16;
  logic [15:0]   a16, b16, out16, hi16;
  logic [3:0]    sel16;
  logic          c16, z16, n16, v16, d16;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid),
    .ALU_Out(ALU_Out), .ALU_Hi(ALU_Hi), .CarryOut(CarryOut),
    .zero(zero), .neg(neg), .ovf(ovf), .div0(div0)
  );

  alu_seq #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
    .A(a16), .B(b16), .ALU_Sel(sel16), .out_valid(ov16),
    .ALU_Out(out16), .ALU_Hi(hi16), .CarryOut(c16),
    .zero(z16), .neg(n16), .ovf(v16), .div0(d16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] out;
    logic [31:0] hi;
    logic        c, z, n, v, d0;
    int          due;
  } exp_t;

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit unsigned operands.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned m, ua, ub, r, h;
    longint sa, sb, smax, smin;
    m    = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & m;
    ub   = 64'(b) & m;
    smax = longint'(m >> 1);
    smin = -smax - 1;
    sa   = (ua > (m >> 1)) ? longint'(ua) - longint'(m) - 1 : longint'(ua);
    sb   = (ub > (m >> 1)) ? longint'(ub) - longint'(m) - 1 : longint'(ub);
    e    = '{default: '0};
    e.op = op;
    r    = 0;
    h    = 0;
    case (op)
      4'd0: begin r = ua + ub; e.c = (r > m);   e.v = (sa + sb > smax) || (sa + sb < smin); end
      4'd1: begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > smax) || (sa - sb < smin); end
      4'd2: begin r = ua * ub; h = r >> w; e.c = (h != 0); end
      4'd3: begin
        if (ub == 0) begin r = m; h = ua; e.d0 = 1'b1; end
        else begin r = ua / ub; h = ua % ub; end
      end
      4'd4: begin r = ua << 1; e.c = ((ua >> (w - 1)) & 1) != 0; end
      4'd5: begin r = ua >> 1; e.c = (ua & 1) != 0; end
      4'd6: begin r = (ua << 1) | (ua >> (w - 1)); e.c = ((ua >> (w - 1)) & 1) != 0; end
      4'd7: begin r = (ua >> 1) | ((ua & 1) << (w - 1)); e.c = (ua & 1) != 0; end
      4'd8:  r = ua & ub;
      4'd9:  r = ua | ub;
      4'd10: r = ua ^ ub;
      4'd11: r = ~(ua | ub);
      4'd12: r = ~(ua & ub);
      4'd13: r = ~(ua ^ ub);
      4'd14: r = (ua > ub) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    r     = r & m;
    e.out = 32'(r);
    e.hi  = 32'(h & m);
    e.z   = (r == 0);
    e.n   = ((r >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3);
  endfunction

  // Scoreboard for the 8-bit instance.
  exp_t q[$];
  exp_t last = '{default: '0};
  int   ncyc     = 0;
  int   busy_end = 0;
  bit   mon_on   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    bit   exp_v;
    ncyc++;
    if (mon_on) begin
      check("in_ready", in_ready, ncyc > busy_end);
      exp_v = (q.size() > 0) && (q[0].due == ncyc);
      check($sformatf("op%0d out_valid", exp_v ? q[0].op : last.op), out_valid, exp_v);
      if (exp_v) last = q.pop_front();
      check($sformatf("op%0d ALU_Out", last.op),  ALU_Out,  last.out);
      check($sformatf("op%0d ALU_Hi", last.op),   ALU_Hi,   last.hi);
      check($sformatf("op%0d CarryOut", last.op), CarryOut, last.c);
      check($sformatf("op%0d zero", last.op),     zero,     last.z);
      check($sformatf("op%0d neg", last.op),      neg,      last.n);
      check($sformatf("op%0d ovf", last.op),      ovf,      last.v);
      check($sformatf("op%0d div0", last.op),     div0,     last.d0);
      if (rst) begin
        q.delete();
        last     = '{default: '0};
        busy_end = 0;
      end else if (in_valid && (ncyc > busy_end)) begin
        e = model(W, ALU_Sel, 32'(A), 32'(B));
        if (is_iter(ALU_Sel)) begin
          e.due    = ncyc + W + 1;
          busy_end = ncyc + W;
        end else begin
          e.due = ncyc + 1;
        end
        q.push_back(e);
      end
    end
  end

  // Present an op and hold it until the DUT takes it; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    ALU_Sel  = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   k   = 0;
    int   lat = 0;
    e     = model(W16, op, 32'(a), 32'(b));
    sel16 = op;
    a16   = a;
    b16   = b;
    iv16  = 1'b1;
    @(negedge clk);
    while (!rdy16 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("w16 accept_wait", rdy16, 1'b1);
    @(posedge clk);
    #1 iv16 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov16 && lat < 64);
    check($sformatf("w16 op%0d latency", op), lat, is_iter(op) ? W16 + 1 : 1);
    check($sformatf("w16 op%0d ALU_Out", op), out16, e.out);
    check($sformatf("w16 op%0d ALU_Hi", op),  hi16,  e.hi);
    check($sformatf("w16 op%0d flags", op), {c16, z16, n16, v16, d16}, {e.c, e.z, e.n, e.v, e.d0});
  endtask

  initial begin
    exp_t e;
    int   k;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0;
    iv16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0;

    // Hand-computed values that pin the reference model.
    e = model(W, 4'd0,  32'h0A, 32'h02); check("model add", e.out, 8'h0C);
    e = model(W, 4'd1,  32'h0A, 32'h02); check("model sub", e.out, 8'h08);
    e = model(W, 4'd4,  32'h0A, 32'h02); check("model shl", e.out, 8'h14);
    e = model(W, 4'd7,  32'h0A, 32'h02); check("model ror", e.out, 8'h05);
    e = model(W, 4'd14, 32'h0A, 32'h02); check("model gt",  e.out, 8'h01);
    e = model(W, 4'd15, 32'h0A, 32'h02); check("model eq",  e.out, 8'h00);
    e = model(W, 4'd2,  32'h0A, 32'h02); check("model mul 0a*02", {e.hi, e.out}, {32'h00, 32'h14});
    e = model(W, 4'd3,  32'h0A, 32'h02); check("model div 0a/02", {e.hi, e.out}, {32'h00, 32'h05});
    e = model(W, 4'd0,  32'hF6, 32'h0A); check("model add f6+0a", {e.out, e.c, e.z, e.v}, {32'h00, 3'b110});
    e = model(W, 4'd1,  32'hF6, 32'h0A); check("model sub f6-0a", {e.out, e.c, e.n}, {32'hEC, 2'b01});
    e = model(W, 4'd2,  32'hF6, 32'h0A); check("model mul f6*0a", {e.hi, e.out, e.c}, {32'h09, 32'h9C, 1'b1});
    e = model(W, 4'd3,  32'hF6, 32'h0A); check("model div f6/0a", {e.hi, e.out}, {32'h06, 32'h18});
    e = model(W, 4'd0,  32'h7F, 32'h01); check("model add 7f+01", {e.out, e.v, e.n}, {32'h80, 2'b11});
    e = model(W, 4'd3,  32'h33, 32'h00); check("model div0", {e.hi, e.out, e.d0}, {32'h33, 32'hFF, 1'b1});
    e = model(W16, 4'd2, 32'hFFFF, 32'hFFFF); check("model mul16", {e.hi, e.out}, {32'hFFFE, 32'h0001});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset outputs", {ALU_Out, ALU_Hi, CarryOut, zero, neg, ovf, div0}, '0);
    check("reset w16 in_ready", rdy16, 1'b1);

    // Op sweep with in_valid held throughout.
    for (int op = 0; op < 16; op++) issue(4'(op), 8'h0A, 8'h02);
    idle(W + 3);

    // Carry, overflow and divide-by-zero corners.
    issue(4'd0, 8'hF6, 8'h0A);
    issue(4'd1, 8'hF6, 8'h0A);
    issue(4'd2, 8'hF6, 8'h0A);
    issue(4'd3, 8'hF6, 8'h0A);
    issue(4'd0, 8'h7F, 8'h01);
    issue(4'd3, 8'h33, 8'h00);
    idle(W + 3);

    // Reset four cycles into a MUL must abort it cleanly.
    issue(4'd2, 8'hF6, 8'h0A);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort out_valid", out_valid, 1'b0);
    check("abort outputs", {ALU_Out, ALU_Hi, CarryOut, zero, neg, ovf, div0}, '0);
    check("abort in_ready", in_ready, 1'b1);
    issue(4'd0, 8'h01, 8'h01);
    check("post-abort add valid", out_valid, 1'b1);
    check("post-abort add result", ALU_Out, 8'h02);
    idle(2);

    // Randomised traffic with occasional gaps and zero divisors.
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(15)), W'($urandom),
            ($urandom_range(7) == 0) ? 8'h00 : W'($urandom));
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    idle(W + 3);

    // 16-bit instance.
    run16(4'd2, 16'hFFFF, 16'hFFFF);
    check("w16 mul literal", {hi16, out16}, 32'hFFFE_0001);
    run16(4'd3, 16'hFFFF, 16'h0000);
    run16(4'd0, 16'h7FFF, 16'h0001);
    for (int i = 0; i < 20; i++)
      run16(4'($urandom_range(15)), 16'($urandom), 16'($urandom));

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("scoreboard drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
